pit_table: RTL and testbench

Pending Interest Table stage directly upstream of `fib`. It records outgoing interests and forwards first-seen prefixes to the FIB over the `pit_in_*`/`fib_out_bit` lines. It answers FIB data arrivals (`prefix_ready`) with `start_send_to_pit` or `rejected`, then streams the accepted payload bytes downstream and retires the satisfied entry.

---
 rtl/pit_table_if.sv | 53 +++++
 rtl/pit_table.sv | 189 ++++++++++++++++++
 tb/tb_pit_table.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pit_table_if.sv
// Bus bundle for pit_table: interest intake, FIB forward/return lines, payload stream.
// The slave modport is the table's view; master is the surrounding pipeline's view.
interface pit_table_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: an interest transfers on a rising edge where interest_valid and
  // interest_ready are both high; interest_ready never depends on interest_valid.
  // All other strobes (fib_out_bit, prefix_ready, rejected, start_send_to_pit,
  // interest_drop, data_out_valid) are single-cycle pulses with no back-pressure.
  logic          interest_valid;
  logic [63:0]   interest_prefix;
  logic [5:0]    interest_len;
  logic          interest_ready;
  logic          interest_drop;

  logic [63:0]   pit_in_prefix;
  logic [5:0]    pit_in_len;
  logic          fib_out_bit;

  logic [63:0]   pit_out_prefix;
  logic [5:0]    pit_out_len;
  logic          prefix_ready;
  logic [7:0]    out_data;

  logic          rejected;
  logic          start_send_to_pit;
  logic [7:0]    data_out;
  logic          data_out_valid;
  logic          data_out_last;

  logic [CW-1:0] pending_count;
  logic [1:0]    fsm_state;

  modport master (
    output interest_valid, interest_prefix, interest_len,
    output pit_out_prefix, pit_out_len, prefix_ready, out_data,
    input  interest_ready, interest_drop,
    input  pit_in_prefix, pit_in_len, fib_out_bit,
    input  rejected, start_send_to_pit, data_out, data_out_valid, data_out_last,
    input  pending_count, fsm_state
  );

  modport slave (
    input  interest_valid, interest_prefix, interest_len,
    input  pit_out_prefix, pit_out_len, prefix_ready, out_data,
    output interest_ready, interest_drop,
    output pit_in_prefix, pit_in_len, fib_out_bit,
    output rejected, start_send_to_pit, data_out, data_out_valid, data_out_last,
    output pending_count, fsm_state
  );
endinterface

// File: rtl/pit_table.sv
// pit_table: Pending Interest Table in front of the FIB. Records interests, forwards
// first-seen prefixes, answers data arrivals and streams accepted payloads.
// Optional macro PIT_TIMEOUT_EN builds per-entry lifetime timers.
module pit_table #(
  parameter int DEPTH         = 4,
  parameter int PAYLOAD_BYTES = 8,
  parameter int LIFETIME      = 1000
) (
  input logic        clk,
  input logic        rst,
  pit_table_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_BYTES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RESP   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  // Out-of-range parameters surface as a named scope in the elaborated hierarchy.
  if (LIFETIME < 1 || LIFETIME > 65535 || PAYLOAD_BYTES < 1 || PAYLOAD_BYTES > 255
      || DEPTH < 2 || DEPTH > 16) begin : g_param_out_of_range
  end

  logic [1:0]       state;
  logic [DEPTH-1:0] valid_q;
  logic [63:0]      prefix_q [DEPTH];
  logic [5:0]       len_q    [DEPTH];
  logic [63:0]      resp_prefix;
  logic [5:0]       resp_len;
  logic [7:0]       byte_cnt;
  logic [CW-1:0]    count_q;

  logic             fwd_q;
  logic [63:0]      fwd_prefix_q;
  logic [5:0]       fwd_len_q;
  logic             drop_q;
  logic [7:0]       dout_q;
  logic             dvalid_q;
  logic             dlast_q;

  logic             accept_int;
  logic             int_hit;
  logic             has_free;
  logic [IW-1:0]    free_idx;
  logic [DEPTH-1:0] resp_hit_vec;
  logic             resp_hit;
  logic             do_insert;
  logic             do_drop;
  logic [DEPTH-1:0] expire_vec;
  logic [DEPTH-1:0] valid_next;
  logic [CW-1:0]    count_next;

  assign bus.interest_ready = (state == S_IDLE) && !bus.prefix_ready;
  assign accept_int         = bus.interest_valid && bus.interest_ready;

  // All lookups use pre-edge table state; descending scan leaves the lowest free index.
  always_comb begin
    int_hit      = 1'b0;
    has_free     = 1'b0;
    free_idx     = '0;
    resp_hit_vec = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && prefix_q[i] == bus.interest_prefix && len_q[i] == bus.interest_len)
        int_hit = 1'b1;
      if (valid_q[i] && prefix_q[i] == resp_prefix && len_q[i] == resp_len)
        resp_hit_vec[i] = 1'b1;
      if (!valid_q[i]) begin
        has_free = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  assign resp_hit  = |resp_hit_vec;
  assign do_drop   = accept_int && (bus.interest_len == 6'd0 || (!int_hit && !has_free));
  assign do_insert = accept_int && bus.interest_len != 6'd0 && !int_hit && has_free;

`ifdef PIT_TIMEOUT_EN
  logic [15:0] timer_q [DEPTH];

  always_comb begin
    expire_vec = '0;
    for (int i = 0; i < DEPTH; i++)
      expire_vec[i] = valid_q[i] && timer_q[i] == 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) timer_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_insert && free_idx == IW'(i))
          timer_q[i] <= 16'(LIFETIME);
        else if (valid_q[i] && timer_q[i] != 16'd0)
          timer_q[i] <= timer_q[i] - 16'd1;
      end
    end
  end
`else
  assign expire_vec = '0;
`endif

  // A RESP hit on an entry that also expires this edge still counts as a hit.
  always_comb begin
    valid_next = valid_q & ~expire_vec;
    if (state == S_RESP) valid_next = valid_next & ~resp_hit_vec;
    if (do_insert) valid_next[free_idx] = 1'b1;
    count_next = '0;
    for (int i = 0; i < DEPTH; i++)
      count_next = count_next + CW'(valid_next[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        prefix_q[i] <= '0;
        len_q[i]    <= '0;
      end
    end else if (do_insert) begin
      prefix_q[free_idx] <= bus.interest_prefix;
      len_q[free_idx]    <= bus.interest_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      valid_q      <= '0;
      count_q      <= '0;
      resp_prefix  <= '0;
      resp_len     <= '0;
      byte_cnt     <= '0;
      fwd_q        <= 1'b0;
      fwd_prefix_q <= '0;
      fwd_len_q    <= '0;
      drop_q       <= 1'b0;
      dout_q       <= '0;
      dvalid_q     <= 1'b0;
      dlast_q      <= 1'b0;
    end else begin
      valid_q      <= valid_next;
      count_q      <= count_next;
      fwd_q        <= do_insert;
      fwd_prefix_q <= do_insert ? bus.interest_prefix : 64'd0;
      fwd_len_q    <= do_insert ? bus.interest_len : 6'd0;
      drop_q       <= do_drop;
      dout_q       <= '0;
      dvalid_q     <= 1'b0;
      dlast_q      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.prefix_ready) begin
            resp_prefix <= bus.pit_out_prefix;
            resp_len    <= bus.pit_out_len;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          byte_cnt <= '0;
          state    <= resp_hit ? S_STREAM : S_IDLE;
        end
        S_STREAM: begin
          dout_q   <= bus.out_data;
          dvalid_q <= 1'b1;
          dlast_q  <= (byte_cnt == LAST_IDX);
          byte_cnt <= byte_cnt + 8'd1;
          if (byte_cnt == LAST_IDX) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The response pulses live for exactly the single RESP cycle.
  assign bus.start_send_to_pit = (state == S_RESP) && resp_hit;
  assign bus.rejected          = (state == S_RESP) && !resp_hit;

  assign bus.fib_out_bit    = fwd_q;
  assign bus.pit_in_prefix  = fwd_prefix_q;
  assign bus.pit_in_len     = fwd_len_q;
  assign bus.interest_drop  = drop_q;
  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = dvalid_q;
  assign bus.data_out_last  = dlast_q;
  assign bus.pending_count  = count_q;
  assign bus.fsm_state      = state;
endmodule

// File: tb/tb_pit_table.sv
// Directed bench for pit_table: drivers push expected output events (tagged with
// the cycle they must appear in) to a queue; a negedge monitor pops and compares.
module tb_pit_table;
  localparam int DEPTH = 4;
  localparam int PB    = 8;
  localparam int LIFE  = 50;
  localparam int W     = 98;

  localparam logic [2:0] K_FWD   = 3'd1;
  localparam logic [2:0] K_DROP  = 3'd2;
  localparam logic [2:0] K_REJ   = 3'd3;
  localparam logic [2:0] K_START = 3'd4;
  localparam logic [2:0] K_DATA  = 3'd5;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   errors;
  logic [W-1:0] exp_q[$];

  pit_table_if #(.DEPTH(DEPTH)) bus ();

  pit_table #(.DEPTH(DEPTH), .PAYLOAD_BYTES(PB), .LIFETIME(LIFE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] ev(input logic [2:0] k, input logic [63:0] p,
                                      input logic [5:0] l, input logic [7:0] b,
                                      input logic last, input int tag);
    return {k, p, l, b, last, 16'(tag)};
  endfunction

  // Scoreboard
  task automatic check_event(input string name, input logic [W-1:0] got);
    logic [W-1:0] want;
    vectors++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got event %h, required no event", name, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got event %h, required %h", name, got, want);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fib_out_bit)
        check_event("forward", ev(K_FWD, bus.pit_in_prefix, bus.pit_in_len, 8'd0, 1'b0, cyc));
      if (bus.interest_drop)
        check_event("drop", ev(K_DROP, 64'd0, 6'd0, 8'd0, 1'b0, cyc));
      if (bus.rejected)
        check_event("rejected", ev(K_REJ, 64'd0, 6'd0, 8'd0, 1'b0, cyc));
      if (bus.start_send_to_pit)
        check_event("start_send", ev(K_START, 64'd0, 6'd0, 8'd0, 1'b0, cyc));
      if (bus.data_out_valid)
        check_event("data_out", ev(K_DATA, 64'd0, 6'd0, bus.data_out, bus.data_out_last, cyc));
    end
  end

  // Drivers. kind: 0 forwarded, 1 dropped, 2 aggregated silently.
  task automatic send_interest(input logic [63:0] p, input logic [5:0] l, input int kind);
    int t;
    int waited;
    @(negedge clk);
    bus.interest_valid  = 1'b1;
    bus.interest_prefix = p;
    bus.interest_len    = l;
    waited = 0;
    while (!bus.interest_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.interest_ready) begin
      vectors++;
      errors++;
      $display("FAIL interest_ready_wait: got ready 0 for 20 cycles, required 1");
      bus.interest_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    t = cyc;
    bus.interest_valid = 1'b0;
    if (kind == 0) exp_q.push_back(ev(K_FWD, p, l, 8'd0, 1'b0, t));
    else if (kind == 1) exp_q.push_back(ev(K_DROP, 64'd0, 6'd0, 8'd0, 1'b0, t));
  endtask

  task automatic send_data(input logic [63:0] p, input logic [5:0] l, input bit hit,
                           input logic [7:0] base);
    int t;
    @(negedge clk);
    bus.prefix_ready   = 1'b1;
    bus.pit_out_prefix = p;
    bus.pit_out_len    = l;
    @(posedge clk);
    #1;
    t = cyc;
    bus.prefix_ready = 1'b0;
    if (!hit) begin
      exp_q.push_back(ev(K_REJ, 64'd0, 6'd0, 8'd0, 1'b0, t));
      @(posedge clk);
      #1;
    end else begin
      exp_q.push_back(ev(K_START, 64'd0, 6'd0, 8'd0, 1'b0, t));
      for (int k = 0; k < PB; k++)
        exp_q.push_back(ev(K_DATA, 64'd0, 6'd0, base + 8'(k), k == PB - 1, t + 2 + k));
      @(posedge clk);
      for (int k = 0; k < PB; k++) begin
        #1 bus.out_data = base + 8'(k);
        @(posedge clk);
      end
      #1 bus.out_data = 8'd0;
    end
  endtask

  task automatic check_count(input string name, input int want);
    @(negedge clk);
    check_val(name, 64'(bus.pending_count), 64'(want));
  endtask

  // Directed sequence
  initial begin
    int t;
    vectors = 0;
    errors  = 0;
    rst = 1'b1;
    bus.interest_valid  = 1'b0;
    bus.interest_prefix = '0;
    bus.interest_len    = '0;
    bus.pit_out_prefix  = '0;
    bus.pit_out_len     = '0;
    bus.prefix_ready    = 1'b0;
    bus.out_data        = '0;
    repeat (2) @(negedge clk);
    check_val("reset_count", 64'(bus.pending_count), 64'd0);
    check_val("reset_state", 64'(bus.fsm_state), 64'd0);
    check_val("reset_fwd", 64'(bus.fib_out_bit), 64'd0);
    check_val("reset_dvalid", 64'(bus.data_out_valid), 64'd0);
    rst = 1'b0;

    send_interest(64'h0000FFFF0000FFFF, 6'd10, 0);
    check_count("count_after_first", 1);
    send_interest(64'h0000FFFF0000FFFF, 6'd10, 2);
    check_count("count_after_aggregate", 1);
    send_interest(64'h0000FFFF0000FFFF, 6'd0, 1);
    check_count("count_after_len0", 1);
    send_data(64'h1234, 6'd10, 1'b0, 8'h00);
    check_count("count_after_reject", 1);
    send_data(64'h0000FFFF0000FFFF, 6'd11, 1'b0, 8'h00);
    send_data(64'h0000FFFF0000FFFF, 6'd10, 1'b1, 8'h01);
    check_count("count_after_satisfy", 0);

    send_interest(64'h1, 6'd8, 0);
    send_interest(64'h2, 6'd8, 0);
    send_interest(64'h3, 6'd8, 0);
    send_interest(64'h4, 6'd8, 0);
    send_interest(64'h5, 6'd8, 1);
    check_count("count_full", 4);

    // Reset while streaming: three bytes are delivered, the rest are discarded.
    @(negedge clk);
    bus.prefix_ready   = 1'b1;
    bus.pit_out_prefix = 64'h3;
    bus.pit_out_len    = 6'd8;
    @(posedge clk);
    #1;
    t = cyc;
    bus.prefix_ready = 1'b0;
    exp_q.push_back(ev(K_START, 64'd0, 6'd0, 8'd0, 1'b0, t));
    for (int k = 0; k < 3; k++)
      exp_q.push_back(ev(K_DATA, 64'd0, 6'd0, 8'h30 + 8'(k), 1'b0, t + 2 + k));
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      #1 bus.out_data = 8'h30 + 8'(k);
      @(posedge clk);
    end
    #1 bus.out_data = 8'h33;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_val("rst_dvalid", 64'(bus.data_out_valid), 64'd0);
    check_val("rst_dout", 64'(bus.data_out), 64'd0);
    check_val("rst_count", 64'(bus.pending_count), 64'd0);
    check_val("rst_state", 64'(bus.fsm_state), 64'd0);
    bus.out_data = 8'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_data(64'h1, 6'd8, 1'b0, 8'h00);

    send_interest(64'hCAFE_0000_0000_0001, 6'd63, 0);
    t = cyc;
`ifdef PIT_TIMEOUT_EN
    while (cyc < t + LIFE - 1) @(negedge clk);
    check_val("count_before_expiry", 64'(bus.pending_count), 64'd1);
    @(negedge clk);
    check_val("count_at_expiry", 64'(bus.pending_count), 64'd0);
    send_data(64'hCAFE_0000_0000_0001, 6'd63, 1'b0, 8'h00);
`else
    while (cyc < t + LIFE + 10) @(negedge clk);
    check_val("count_persists", 64'(bus.pending_count), 64'd1);
    send_data(64'hCAFE_0000_0000_0001, 6'd63, 1'b1, 8'hA0);
    check_count("count_after_late_hit", 0);
`endif

    repeat (4) @(negedge clk);
    check_val("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
